// File: rtl/AluCtrlSig_pkg.sv
// Shared hazard-unit types: pipeline action categories and ALU operand
// forwarding selects, plus the forwarding-priority helper.
package AluCtrlSig_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2,
    STALL    = 2'd3
  } hz_state_t;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_S5 = 2'b01;
  localparam logic [1:0] FWD_S4 = 2'b10;

  // The memory stage holds the younger result, so it wins over writeback.
  function automatic logic [1:0] fwd_sel(
    input logic       rw4,
    input logic [4:0] w4,
    input logic       rw5,
    input logic [4:0] w5,
    input logic [4:0] src
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (rw4 && (w4 != 5'd0) && (w4 == src)) begin
      sel = FWD_S4;
    end else if (rw5 && (w5 != 5'd0) && (w5 == src)) begin
      sel = FWD_S5;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/flush enables, operand forwarding,
// performance counters and a sticky data-memory timeout flag.
module hazard_ctrl
  import AluCtrlSig_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] rs_s2,
  input  logic [4:0] rt_s2,
  input  logic       uses_rt_s2,
  input  logic       memread_s3,
  input  logic [4:0] wrreg_s3,
  input  logic [4:0] rs_s3,
  input  logic [4:0] rt_s3,
  input  logic       regwrite_s4,
  input  logic [4:0] wrreg_s4,
  input  logic       regwrite_s5,
  input  logic [4:0] wrreg_s5,
  input  logic       branch_taken_s4,
  input  logic       mem_busy,
  input  logic       cnt_clr,
  output logic       pc_en,
  output logic       if_id_en,
  output logic       id_ex_en,
  output logic       ex_mem_en,
  output logic       flush_if_id,
  output logic       flush_id_ex,
  output logic       flush_ex_mem,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output hz_state_t  state,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt,
  output logic       mem_timeout
);

  localparam int unsigned BW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [BW-1:0] TO_VAL = BW'(TIMEOUT_CYC);

  logic          w_lu;
  hz_state_t     w_cat;
  logic [BW-1:0] w_busy_nxt;

  hz_state_t     r_state;
  logic [15:0]   r_stall_cnt;
  logic [15:0]   r_flush_cnt;
  logic [BW-1:0] r_busy_cnt;
  logic          r_timeout;

  always_comb begin
    w_lu = memread_s3 && (wrreg_s3 != 5'd0) &&
           ((wrreg_s3 == rs_s2) || (uses_rt_s2 && (wrreg_s3 == rt_s2)));

    w_cat = RUN;
    if (mem_busy)             w_cat = MEM_WAIT;
    else if (branch_taken_s4) w_cat = FLUSH;
    else if (w_lu)            w_cat = STALL;

    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    flush_ex_mem = 1'b0;

    // In reset the PC holds while every stage register is loaded with a NOP.
    if (!rst_n) begin
      pc_en        = 1'b0;
      flush_if_id  = 1'b1;
      flush_id_ex  = 1'b1;
      flush_ex_mem = 1'b1;
    end else begin
      case (w_cat)
        MEM_WAIT: begin
          pc_en     = 1'b0;
          if_id_en  = 1'b0;
          id_ex_en  = 1'b0;
          ex_mem_en = 1'b0;
        end
        FLUSH: begin
          flush_if_id  = 1'b1;
          flush_id_ex  = 1'b1;
          flush_ex_mem = 1'b1;
        end
        STALL: begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          flush_id_ex = 1'b1;
        end
        default: ;
      endcase
    end

    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (rst_n) begin
      fwd_a = fwd_sel(regwrite_s4, wrreg_s4, regwrite_s5, wrreg_s5, rs_s3);
      fwd_b = fwd_sel(regwrite_s4, wrreg_s4, regwrite_s5, wrreg_s5, rt_s3);
    end

    if (!mem_busy)              w_busy_nxt = '0;
    else if (r_busy_cnt == '1)  w_busy_nxt = r_busy_cnt;
    else                        w_busy_nxt = r_busy_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= RUN;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_busy_cnt  <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_state <= w_cat;
      if (cnt_clr) begin
        r_stall_cnt <= '0;
        r_flush_cnt <= '0;
      end else begin
        if (((w_cat == MEM_WAIT) || (w_cat == STALL)) && (r_stall_cnt != '1))
          r_stall_cnt <= r_stall_cnt + 16'd1;
        if ((w_cat == FLUSH) && (r_flush_cnt != '1))
          r_flush_cnt <= r_flush_cnt + 16'd1;
      end
      r_busy_cnt <= w_busy_nxt;
      if (w_busy_nxt >= TO_VAL) r_timeout <= 1'b1;
    end
  end

  assign state       = r_state;
  assign stall_cnt   = r_stall_cnt;
  assign flush_cnt   = r_flush_cnt;
  assign mem_timeout = r_timeout;

endmodule
